pad_ctrl: RTL and testbench

// - Core-side owner of the pad-ring signal bundle: drives every pad control line and registers core outputs/OEs.
// - Synchronises all pad inputs into the clk60 domain.
// - Holds per-pad configuration written through a valid/ready port; the config can be locked until reset.
// - Sits inside chip_core between the pad ports and the user logic (chess engine, UART, etc.).

---
 rtl/pad_ctrl_pkg.sv | 28 ++
 rtl/pad_sync.sv | 25 ++
 rtl/pad_ctrl.sv | 143 ++++++++++++++
 tb/tb_pad_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_ctrl_pkg.sv
// Shared types, reset values and helpers for the pad-ring controller.
package pad_ctrl_pkg;

  typedef struct packed {
    logic oe_en;
    logic cs;
    logic sl;
    logic ie;
    logic pu;
    logic pd;
  } pad_cfg_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } cfg_state_t;

  localparam pad_cfg_t BIDIR_CFG_RST = '{oe_en: 1'b0, cs: 1'b0, sl: 1'b0,
                                         ie: 1'b1, pu: 1'b0, pd: 1'b1};
  localparam logic INPUT_PU_RST = 1'b0;
  localparam logic INPUT_PD_RST = 1'b1;

  // Both pulls on would fight in the pad; resolve to pull-down only.
  function automatic logic [1:0] normalise_pulls(input logic pu, input logic pd);
    return (pu && pd) ? 2'b01 : {pu, pd};
  endfunction

endpackage

// File: rtl/pad_sync.sv
// Reset-to-zero flop-chain synchroniser; output lags the input by STAGES edges.
module pad_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/pad_ctrl.sv
// Core-side pad-ring owner: pad controls from config registers, registered outputs,
// synchronised inputs and a lockable valid/ready configuration port.
//   state    | meaning
//   ST_IDLE  | cfg_ready=1, a valid request is accepted and written on this edge
//   ST_APPLY | cfg_ready=0, new config visible on pins, cfg_err shows the verdict
module pad_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int  NUM_INPUT_PADS = 12,
  parameter int  NUM_BIDIR_PADS = 40,
  parameter int  SYNC_STAGES    = 2,
  localparam int CFG_AW         = $clog2(NUM_BIDIR_PADS + NUM_INPUT_PADS + 1)
) (
  input  logic                      clk60,
  input  logic                      rst_ext_n,
  input  logic [NUM_INPUT_PADS-1:0] input_in,
  output logic [NUM_INPUT_PADS-1:0] input_pu,
  output logic [NUM_INPUT_PADS-1:0] input_pd,
  input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
  output logic [NUM_BIDIR_PADS-1:0] bidir_out,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
  output logic [NUM_INPUT_PADS-1:0] core_in,
  output logic [NUM_BIDIR_PADS-1:0] core_bin,
  input  logic [NUM_BIDIR_PADS-1:0] core_bout,
  input  logic [NUM_BIDIR_PADS-1:0] core_boe,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CFG_AW-1:0]         cfg_addr,
  input  logic [5:0]                cfg_data,
  output logic                      cfg_err,
  output logic                      cfg_locked
);

  localparam logic [CFG_AW-1:0] LOCK_ADDR = {CFG_AW{1'b1}};
  localparam logic [CFG_AW-1:0] END_ADDR  = CFG_AW'(NUM_BIDIR_PADS + NUM_INPUT_PADS);

  cfg_state_t                state_q, state_d;
  logic                      accept, wr_err, err_q, locked_q;
  pad_cfg_t                  wr_cfg;
  pad_cfg_t                  bidir_cfg_q [NUM_BIDIR_PADS];
  logic [NUM_INPUT_PADS-1:0] input_pu_q, input_pd_q;
  logic [NUM_BIDIR_PADS-1:0] oe_en_vec;

  always_ff @(posedge clk60 or negedge rst_ext_n) begin
    if (!rst_ext_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cfg_valid) state_d = ST_APPLY;
      ST_APPLY: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q == ST_IDLE);
    cfg_err   = (state_q == ST_APPLY) && err_q;
    accept    = (state_q == ST_IDLE) && cfg_valid;
  end

  // Lock writes are legal until the lock itself is set; only holes in the map are errors.
  assign wr_err = locked_q || ((cfg_addr >= END_ADDR) && (cfg_addr != LOCK_ADDR));

  always_comb begin
    wr_cfg = pad_cfg_t'(cfg_data);
    {wr_cfg.pu, wr_cfg.pd} = normalise_pulls(cfg_data[1], cfg_data[0]);
  end

  always_ff @(posedge clk60 or negedge rst_ext_n) begin
    if (!rst_ext_n) begin
      for (int i = 0; i < NUM_BIDIR_PADS; i++) bidir_cfg_q[i] <= BIDIR_CFG_RST;
      input_pu_q <= {NUM_INPUT_PADS{INPUT_PU_RST}};
      input_pd_q <= {NUM_INPUT_PADS{INPUT_PD_RST}};
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else if (accept) begin
      err_q <= wr_err;
      if (!wr_err) begin
        for (int i = 0; i < NUM_BIDIR_PADS; i++)
          if (cfg_addr == CFG_AW'(i)) bidir_cfg_q[i] <= wr_cfg;
        for (int j = 0; j < NUM_INPUT_PADS; j++)
          if (cfg_addr == CFG_AW'(NUM_BIDIR_PADS + j)) begin
            input_pu_q[j] <= wr_cfg.pu;
            input_pd_q[j] <= wr_cfg.pd;
          end
        if ((cfg_addr == LOCK_ADDR) && cfg_data[0]) locked_q <= 1'b1;
      end
    end
  end

  always_comb begin
    oe_en_vec = '0;
    bidir_cs  = '0;
    bidir_sl  = '0;
    bidir_ie  = '0;
    bidir_pu  = '0;
    bidir_pd  = '0;
    for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
      oe_en_vec[i] = bidir_cfg_q[i].oe_en;
      bidir_cs[i]  = bidir_cfg_q[i].cs;
      bidir_sl[i]  = bidir_cfg_q[i].sl;
      bidir_ie[i]  = bidir_cfg_q[i].ie;
      bidir_pu[i]  = bidir_cfg_q[i].pu;
      bidir_pd[i]  = bidir_cfg_q[i].pd;
    end
  end

  assign input_pu   = input_pu_q;
  assign input_pd   = input_pd_q;
  assign cfg_locked = locked_q;

  always_ff @(posedge clk60 or negedge rst_ext_n) begin
    if (!rst_ext_n) begin
      bidir_out <= '0;
      bidir_oe  <= '0;
    end else begin
      bidir_out <= core_bout;
      bidir_oe  <= core_boe & oe_en_vec;
    end
  end

  pad_sync #(.WIDTH(NUM_INPUT_PADS), .STAGES(SYNC_STAGES)) u_sync_input (
    .clk   (clk60),
    .rst_n (rst_ext_n),
    .d     (input_in),
    .q     (core_in)
  );

  pad_sync #(.WIDTH(NUM_BIDIR_PADS), .STAGES(SYNC_STAGES)) u_sync_bidir (
    .clk   (clk60),
    .rst_n (rst_ext_n),
    .d     (bidir_in),
    .q     (core_bin)
  );

endmodule

// File: tb/tb_pad_ctrl.sv
// Bench for pad_ctrl: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against a behavioural model.
module tb_pad_ctrl;

  localparam int NI = 12;
  localparam int NB = 40;
  localparam int SS = 2;
  localparam logic [63:0] ALL_B = (64'd1 << NB) - 64'd1;
  localparam logic [63:0] ALL_I = (64'd1 << NI) - 64'd1;

  logic          clk60 = 1'b0;
  logic          rst_ext_n;
  logic [NI-1:0] input_in, input_pu, input_pd, core_in;
  logic [NB-1:0] bidir_in, bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
  logic [NB-1:0] core_bin, core_bout, core_boe;
  logic          cfg_valid, cfg_ready, cfg_err, cfg_locked;
  logic [5:0]    cfg_addr, cfg_data;

  pad_ctrl #(.NUM_INPUT_PADS(NI), .NUM_BIDIR_PADS(NB), .SYNC_STAGES(SS)) dut (
    .clk60(clk60), .rst_ext_n(rst_ext_n),
    .input_in(input_in), .input_pu(input_pu), .input_pd(input_pd),
    .bidir_in(bidir_in), .bidir_out(bidir_out), .bidir_oe(bidir_oe),
    .bidir_cs(bidir_cs), .bidir_sl(bidir_sl), .bidir_ie(bidir_ie),
    .bidir_pu(bidir_pu), .bidir_pd(bidir_pd),
    .core_in(core_in), .core_bin(core_bin), .core_bout(core_bout), .core_boe(core_boe),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .cfg_locked(cfg_locked)
  );

  always #5 clk60 = ~clk60;

  int   total = 0;
  int   bad   = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-field config vectors, a one-write-per-two-cycles port, delay queues.
  logic [NB-1:0] m_oe_en, m_cs, m_sl, m_ie, m_pu, m_pd, m_out, m_oe;
  logic [NI-1:0] m_ipu, m_ipd;
  logic          m_locked, m_ready, m_err;
  logic [NI-1:0] q_in[$];
  logic [NB-1:0] q_bin[$];

  task automatic model_write(input int a, input logic [5:0] d);
    logic pu, pd;
    pu = d[1] & ~d[0];
    pd = d[0];
    m_err = m_locked || (a >= NB + NI && a != 63);
    if (!m_err) begin
      if (a < NB) begin
        m_oe_en[a] = d[5]; m_cs[a] = d[4]; m_sl[a] = d[3]; m_ie[a] = d[2];
        m_pu[a] = pu; m_pd[a] = pd;
      end else if (a < NB + NI) begin
        m_ipu[a-NB] = pu; m_ipd[a-NB] = pd;
      end else if (d[0]) begin
        m_locked = 1'b1;
      end
    end
  endtask

  always @(posedge clk60 or negedge rst_ext_n) begin
    if (!rst_ext_n) begin
      m_oe_en = '0; m_cs = '0; m_sl = '0; m_ie = '1; m_pu = '0; m_pd = '1;
      m_out = '0; m_oe = '0; m_ipu = '0; m_ipd = '1;
      m_locked = 1'b0; m_ready = 1'b1; m_err = 1'b0;
      q_in.delete(); q_bin.delete();
    end else begin
      m_out = core_bout;
      m_oe  = core_boe & m_oe_en;
      q_in.push_back(input_in);
      if (q_in.size() > SS) void'(q_in.pop_front());
      q_bin.push_back(bidir_in);
      if (q_bin.size() > SS) void'(q_bin.pop_front());
      if (m_ready && cfg_valid) begin
        model_write(int'(cfg_addr), cfg_data);
        m_ready = 1'b0;
      end else begin
        m_err   = 1'b0;
        m_ready = 1'b1;
      end
    end
  end

  always @(negedge clk60) begin
    if (cmp_en) begin
      check("bidir_out", 64'(bidir_out), 64'(m_out));
      check("bidir_oe",  64'(bidir_oe),  64'(m_oe));
      check("bidir_cs",  64'(bidir_cs),  64'(m_cs));
      check("bidir_sl",  64'(bidir_sl),  64'(m_sl));
      check("bidir_ie",  64'(bidir_ie),  64'(m_ie));
      check("bidir_pu",  64'(bidir_pu),  64'(m_pu));
      check("bidir_pd",  64'(bidir_pd),  64'(m_pd));
      check("input_pu",  64'(input_pu),  64'(m_ipu));
      check("input_pd",  64'(input_pd),  64'(m_ipd));
      check("core_in",   64'(core_in),   (q_in.size() == SS) ? 64'(q_in[0]) : 64'd0);
      check("core_bin",  64'(core_bin),  (q_bin.size() == SS) ? 64'(q_bin[0]) : 64'd0);
      check("cfg_ready", 64'(cfg_ready), 64'(m_ready));
      check("cfg_err",   64'(cfg_err),   64'(m_err));
      check("cfg_locked", 64'(cfg_locked), 64'(m_locked));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk60);
      #2;
    end
  endtask

  // Returns 2 time units into the cycle after the accept edge.
  task automatic cfg_write(input logic [5:0] a, input logic [5:0] d);
    int n;
    n = 0;
    cfg_addr = a; cfg_data = d; cfg_valid = 1'b1;
    while (!cfg_ready && n < 8) begin
      step(1);
      n++;
    end
    if (!cfg_ready) begin
      total++;
      bad++;
      $display("FAIL cfg_write_timeout addr=%0d: ready got 0 want 1", a);
    end
    step(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         acc;
    logic [5:0] rdy_pat;
    logic       last_ready;
    logic [5:0] a;
    int         r;

    rst_ext_n = 1'b0;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    core_bout = '0; core_boe = '0; input_in = '0; bidir_in = '0;
    step(2);
    cmp_en = 1'b1;

    check("rst_ie", 64'(bidir_ie), ALL_B);
    check("rst_pd", 64'(bidir_pd), ALL_B);
    check("rst_oe", 64'(bidir_oe), 64'd0);
    check("rst_input_pd", 64'(input_pd), ALL_I);
    check("rst_ready", 64'(cfg_ready), 64'd1);
    check("rst_locked", 64'(cfg_locked), 64'd0);
    rst_ext_n = 1'b1;
    step(1);
    check("ready_first_edge", 64'(cfg_ready), 64'd1);

    cfg_write(6'd3, 6'b100100);
    check("wr3_pd", 64'(bidir_pd[3]), 64'd0);
    check("wr3_ie", 64'(bidir_ie[3]), 64'd1);
    check("wr3_err", 64'(cfg_err), 64'd0);
    core_boe[3] = 1'b1; core_bout[3] = 1'b1;
    step(1);
    check("oe3_on", 64'(bidir_oe[3]), 64'd1);
    check("out3_on", 64'(bidir_out[3]), 64'd1);
    cfg_write(6'd3, 6'b000100);
    step(1);
    check("oe3_gated", 64'(bidir_oe[3]), 64'd0);
    check("out3_still", 64'(bidir_out[3]), 64'd1);
    core_boe = '0; core_bout = '0;

    step(2);
    input_in[5] = 1'b1;
    step(1);
    check("sync_edge1", 64'(core_in[5]), 64'd0);
    step(1);
    check("sync_edge2", 64'(core_in[5]), 64'd1);
    input_in = '0;

    cfg_write(6'd41, 6'b000010);
    check("in1_pu_set", 64'(input_pu[1]), 64'd1);
    check("in1_pd_clr", 64'(input_pd[1]), 64'd0);
    cfg_write(6'd41, 6'b000011);
    check("conflict_pu", 64'(input_pu[1]), 64'd0);
    check("conflict_pd", 64'(input_pd[1]), 64'd1);
    check("conflict_err", 64'(cfg_err), 64'd0);
    step(1);

    cfg_addr = 6'd10; cfg_data = 6'b011001; cfg_valid = 1'b1;
    acc = 0; rdy_pat = '0;
    for (int i = 0; i < 6; i++) begin
      rdy_pat[i] = cfg_ready;
      if (cfg_ready) acc++;
      step(1);
    end
    cfg_valid = 1'b0;
    check("b2b_accepts", 64'(acc), 64'd3);
    check("b2b_ready_pattern", 64'(rdy_pat), 64'b010101);

    cfg_write(6'd52, 6'b111111);
    check("err52_pulse", 64'(cfg_err), 64'd1);
    check("err52_cs", 64'(bidir_cs), 64'h400);
    check("err52_input_pu", 64'(input_pu), 64'd0);
    step(1);
    check("err52_one_cycle", 64'(cfg_err), 64'd0);

    cfg_write(6'd63, 6'b000000);
    check("lock_noop_err", 64'(cfg_err), 64'd0);
    check("lock_noop", 64'(cfg_locked), 64'd0);
    cfg_write(6'd63, 6'b000001);
    check("lock_set", 64'(cfg_locked), 64'd1);
    check("lock_err", 64'(cfg_err), 64'd0);
    cfg_write(6'd0, 6'b011010);
    check("locked_err", 64'(cfg_err), 64'd1);
    check("locked_cs0", 64'(bidir_cs[0]), 64'd0);
    check("locked_ie0", 64'(bidir_ie[0]), 64'd1);
    step(1);

    rst_ext_n = 1'b0;
    step(2);
    rst_ext_n = 1'b1;
    step(1);
    cfg_write(6'd7, 6'b111010);
    check("pre_rst_cs7", 64'(bidir_cs[7]), 64'd1);
    #1 rst_ext_n = 1'b0;
    #1;
    check("midrst_cs7", 64'(bidir_cs[7]), 64'd0);
    check("midrst_ie", 64'(bidir_ie), ALL_B);
    check("midrst_ready", 64'(cfg_ready), 64'd1);
    check("midrst_err", 64'(cfg_err), 64'd0);
    check("midrst_locked", 64'(cfg_locked), 64'd0);
    step(2);
    rst_ext_n = 1'b1;
    step(1);

    last_ready = cfg_ready;
    for (int c = 0; c < 1500; c++) begin
      if (cfg_valid && last_ready) cfg_valid = 1'b0;
      if (!cfg_valid && $urandom_range(0, 2) == 0) begin
        r = int'($urandom_range(0, 99));
        if (r < 70)      a = 6'($urandom_range(0, NB + NI - 1));
        else if (r < 85) a = 6'($urandom_range(NB + NI, 62));
        else             a = 6'd63;
        cfg_addr = a;
        cfg_data = 6'($urandom);
        if (a == 6'd63 && c < 1100) cfg_data[0] = 1'b0;
        cfg_valid = 1'b1;
      end
      core_bout = NB'({$urandom, $urandom});
      core_boe  = NB'({$urandom, $urandom});
      input_in  = NI'($urandom);
      bidir_in  = NB'({$urandom, $urandom});
      last_ready = cfg_ready;
      step(1);
    end
    cfg_valid = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
